// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared constants and types for the 16 x N-bit register bank
// Contents:
//   REG_N, REG_ADDR_W, REG_COUNT : default geometry of the bank
//   R0_INIT, R15_INIT            : power-up/reset values of R0 and R15
//   reg_word_t                   : one register word
package regbank_pkg;

  localparam int REG_N      = 32;
  localparam int REG_ADDR_W = 4;
  localparam int REG_COUNT  = 2 ** REG_ADDR_W;

  localparam logic [REG_N-1:0] R0_INIT  = 32'h0001_0000;
  localparam logic [REG_N-1:0] R15_INIT = 32'h0001_4008;

  typedef logic [REG_N-1:0] reg_word_t;

endpackage

// File: rtl/n_bits_register.sv
// rtl/n_bits_register.sv - one N-bit register with enable and synchronous reset
// Ports:
//   CLK  in  1  clock, rising edge
//   RST  in  1  synchronous active-high reset, loads RESET_VAL, overrides EN
//   EN   in  1  load enable
//   D    in  N  load data
//   Q    out N  current register value
module n_bits_register #(
  parameter int         N         = 32,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q
);

  // Declaration initialiser gives the power-up value, so the bank is valid
  // before any reset pulse is seen.
  logic [N-1:0] q_q = RESET_VAL;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (EN) begin
      q_d = D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/n_bits_register_bank.sv
// rtl/n_bits_register_bank.sv - 16-entry x N-bit register file, 2 async read ports, 1 sync write port
// Ports:
//   CLK  in  1       clock, all state updates on rising edge
//   RST  in  1       synchronous active-high reset (R0/R15 to constants, others to 0)
//   WE3  in  1       write enable, port 3
//   A1   in  ADDR_W  read address, port 1
//   A2   in  ADDR_W  read address, port 2
//   A3   in  ADDR_W  write address, port 3
//   WD3  in  N       write data, port 3
//   RD1  out N       read data, port 1 (combinational)
//   RD2  out N       read data, port 2 (combinational)
module n_bits_register_bank
  import regbank_pkg::*;
#(
  parameter int           N        = regbank_pkg::REG_N,
  parameter int           ADDR_W   = regbank_pkg::REG_ADDR_W,
  parameter logic [N-1:0] R0_INIT  = regbank_pkg::R0_INIT,
  parameter logic [N-1:0] R15_INIT = regbank_pkg::R15_INIT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [N-1:0]      WD3,
  output logic [N-1:0]      RD1,
  output logic [N-1:0]      RD2
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0] wr_en;
  logic [N-1:0]    reg_q [NREG];

  // One-hot write decode; RST priority is handled inside each register.
  always_comb begin
    wr_en = '0;
    if (WE3) begin
      wr_en[A3] = 1'b1;
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    // First and last registers carry the fixed non-zero constants.
    localparam logic [N-1:0] RV = (i == 0)        ? R0_INIT  :
                                  (i == NREG - 1) ? R15_INIT : '0;
    n_bits_register #(
      .N         (N),
      .RESET_VAL (RV)
    ) u_reg (
      .CLK (CLK),
      .RST (RST),
      .EN  (wr_en[i]),
      .D   (WD3),
      .Q   (reg_q[i])
    );
  end

  // No write-to-read bypass: reads see the stored value until the edge.
  always_comb begin
    RD1 = reg_q[A1];
    RD2 = reg_q[A2];
  end

endmodule

// File: tb/tb_n_bits_register_bank.sv
// tb/tb_n_bits_register_bank.sv - self-checking bench for n_bits_register_bank
module tb_n_bits_register_bank;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WE3 = 1'b0;
  logic [3:0]  A1  = '0;
  logic [3:0]  A2  = '0;
  logic [3:0]  A3  = '0;
  logic [31:0] WD3 = '0;
  logic [31:0] RD1;
  logic [31:0] RD2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [16];

  n_bits_register_bank dut (
    .CLK (CLK),
    .RST (RST),
    .WE3 (WE3),
    .A1  (A1),
    .A2  (A2),
    .A3  (A3),
    .WD3 (WD3),
    .RD1 (RD1),
    .RD2 (RD2)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    model[0]  = 32'd65536;
    model[15] = 32'd81928;
  endtask

  // Advance one rising edge, applying the register-file rules to the model.
  task automatic clk_edge();
    @(posedge CLK);
    if (RST) model_reset();
    else if (WE3) model[A3] = WD3;
    #1;
  endtask

  task automatic read_both(input logic [3:0] a, input logic [3:0] b);
    A1 = a;
    A2 = b;
    #1;
  endtask

  initial begin
    model_reset();

    // 1: power-up values, no reset applied
    read_both(4'd0, 4'd0);
    check("pwrup_r0_rd1", RD1, 32'd65536);
    check("pwrup_r0_rd2", RD2, 32'd65536);
    read_both(4'd15, 4'd15);
    check("pwrup_r15_rd1", RD1, 32'd81928);
    check("pwrup_r15_rd2", RD2, 32'd81928);
    for (int i = 1; i < 15; i++) begin
      read_both(4'(i), 4'(i));
      check("pwrup_zero", RD1, 32'd0);
    end

    // 2: fill R1..R14 with their index
    WE3 = 1'b1;
    for (int i = 1; i < 15; i++) begin
      A3  = 4'(i);
      WD3 = 32'(i);
      clk_edge();
    end
    WE3 = 1'b0;
    for (int i = 1; i < 15; i++) begin
      read_both(4'(i), 4'(i));
      check("fill_rd1", RD1, 32'(i));
      check("fill_rd2", RD2, 32'(i));
    end
    read_both(4'd0, 4'd15);
    check("fill_r0", RD1, 32'd65536);
    check("fill_r15", RD2, 32'd81928);

    // 3: WE3=0 blocks the write
    A3 = 4'd5; WD3 = 32'hDEAD_BEEF;
    clk_edge();
    read_both(4'd5, 4'd5);
    check("we_off_r5", RD1, 32'd5);

    // 4: read during write, old value before the edge, new after
    WE3 = 1'b1; A3 = 4'd7; WD3 = 32'hA5A5_A5A5;
    read_both(4'd7, 4'd7);
    check("rdw_before", RD1, 32'd7);
    clk_edge();
    check("rdw_after", RD1, 32'hA5A5_A5A5);

    // 5: R0/R15 writable, then reset beats a simultaneous write
    A3 = 4'd0;  WD3 = 32'h0000_1234; clk_edge();
    A3 = 4'd15; WD3 = 32'hFFFF_FFFF; clk_edge();
    WE3 = 1'b0;
    read_both(4'd0, 4'd15);
    check("wr_r0", RD1, 32'h0000_1234);
    check("wr_r15", RD2, 32'hFFFF_FFFF);
    RST = 1'b1; WE3 = 1'b1; A3 = 4'd7; WD3 = 32'h7777_7777;
    clk_edge();
    RST = 1'b0; WE3 = 1'b0;
    check("rst_r0", RD1, 32'd65536);
    check("rst_r15", RD2, 32'd81928);
    read_both(4'd7, 4'd5);
    check("rst_r7_nowrite", RD1, 32'd0);
    check("rst_r5", RD2, 32'd0);

    // 6: independent dual-port reads, swap with no clock edge
    WE3 = 1'b1;
    A3 = 4'd3;  WD3 = 32'd3;  clk_edge();
    A3 = 4'd12; WD3 = 32'd12; clk_edge();
    WE3 = 1'b0;
    read_both(4'd3, 4'd12);
    check("dual_rd1", RD1, 32'd3);
    check("dual_rd2", RD2, 32'd12);
    read_both(4'd12, 4'd3);
    check("swap_rd1", RD1, 32'd12);
    check("swap_rd2", RD2, 32'd3);

    // Random traffic against the array model
    for (int n = 0; n < 400; n++) begin
      RST = ($urandom_range(0, 31) == 0);
      WE3 = $urandom_range(0, 1);
      A3  = 4'($urandom_range(0, 15));
      WD3 = $urandom;
      read_both(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      check("rand_rd1", RD1, model[A1]);
      check("rand_rd2", RD2, model[A2]);
      clk_edge();
      check("rand_post_rd1", RD1, model[A1]);
    end
    RST = 1'b0; WE3 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      read_both(4'(i), 4'(15 - i));
      check("final_rd1", RD1, model[i]);
      check("final_rd2", RD2, model[15 - i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
